imem_boot_loader: RTL and testbench

Upstream loader for the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. Each word is written into instruction memory at consecutive word addresses. The core is held in reset until the programmed word count has been written, then released.

---
 rtl/imem_boot_loader.sv | 131 +++++++++++++
 tb/tb_imem_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Receives a length-prefixed byte stream, packs bytes into 32-bit
//            little-endian words, writes them to consecutive instruction
//            memory addresses and holds the core in reset until finished.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              boot_done,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [16:0]     C_MAX_WORDS = 17'(MAX_WORDS);
  localparam logic [ADDR_W:0] C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_word_cnt;   // one extra bit so a full 2**ADDR_W load can terminate
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_word;

  logic              w_xfer;
  logic [15:0]       w_len_full;
  logic              w_len_over;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_last_word;

  assign w_xfer      = rx_valid & rx_ready;
  // Length as it will be once the high byte in flight is captured
  assign w_len_full  = {rx_data, r_len[7:0]};
  assign w_len_over  = {1'b0, w_len_full} > C_MAX_WORDS;
  assign w_cnt_inc   = r_word_cnt + C_CNT_ONE;
  assign w_last_word = 32'(w_cnt_inc) == 32'(r_len);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN0:  if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_len_full == 16'd0) w_next = S_DONE;
          else if (w_len_over)     w_next = S_ERR;
          else                     w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
      S_DONE:  if (reload) w_next = S_LEN0;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_LEN0;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    rx_ready     = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
    imem_we      = (r_state == S_WRITE);
    core_reset   = (r_state != S_DONE);
    boot_done    = (r_state == S_DONE);
    err_overflow = (r_state == S_ERR);
  end

  // Length capture, byte packing and word counting
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_len      <= 16'd0;
      r_word_cnt <= '0;
      r_byte_cnt <= 2'd0;
      r_word     <= 32'd0;
    end else begin
      case (r_state)
        S_LEN0: if (w_xfer) r_len[7:0]  <= rx_data;
        S_LEN1: if (w_xfer) r_len[15:8] <= rx_data;
        S_DATA: begin
          if (w_xfer) begin
            r_word[8*r_byte_cnt +: 8] <= rx_data;
            r_byte_cnt                <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: r_word_cnt <= w_cnt_inc;
        S_DONE: begin
          if (reload) begin
            r_word_cnt <= '0;
            r_byte_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and data are only meaningful while imem_we is high
  assign imem_addr  = r_word_cnt[ADDR_W-1:0];
  assign imem_wdata = r_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Self-checking bench for imem_boot_loader: directed sequences for
//            latency/corner cases plus a table of randomized image loads
//            checked against a list-of-writes reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        boot_done;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .boot_done    (boot_done),
    .err_overflow (err_overflow)
  );

  always #5 CLK = ~CLK;

  // Record every memory write, sampled mid-cycle
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
  endtask

  // Offer one byte after 'gap' idle cycles; returns one step after the transfer edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    while (rx_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int guard = 0;
    while (boot_done !== 1'b1 && err_overflow !== 1'b1 && guard < budget) begin
      tick();
      guard++;
    end
    if (guard >= budget) chk("end_timeout", 32'd0, 32'd1);
  endtask

  // One randomized load; the model is simply the ordered list of (addr, word)
  // writes implied by the stream format, or nothing for empty/oversized images.
  task automatic run_load(input int len, input int gap_max, input bit exp_err);
    logic [31:0] words[$];
    int          nexp;
    clear_log();
    for (int i = 0; i < len && len <= 256; i++) words.push_back($urandom);
    send_byte(8'(len), $urandom_range(gap_max, 0));
    send_byte(8'(len >> 8), $urandom_range(gap_max, 0));
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], $urandom_range(gap_max, 0));
    end
    wait_end(20);
    tick();
    nexp = words.size();
    chk($sformatf("len%0d_done", len), 32'(boot_done), 32'(!exp_err));
    chk($sformatf("len%0d_err", len), 32'(err_overflow), 32'(exp_err));
    chk($sformatf("len%0d_core_reset", len), 32'(core_reset), 32'(exp_err));
    chk($sformatf("len%0d_nwrites", len), 32'(got_addr.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
      chk($sformatf("len%0d_addr%0d", len, i), 32'(got_addr[i]), 32'(i % 256));
      chk($sformatf("len%0d_data%0d", len, i), got_data[i], words[i]);
    end
  endtask

  typedef struct {
    int len;
    int gap_max;
    bit exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{len: 3,   gap_max: 0, exp_err: 1'b0};
    tbl[1] = '{len: 5,   gap_max: 3, exp_err: 1'b0};
    tbl[2] = '{len: 1,   gap_max: 5, exp_err: 1'b0};
    tbl[3] = '{len: 0,   gap_max: 2, exp_err: 1'b0};
    tbl[4] = '{len: 256, gap_max: 0, exp_err: 1'b0};
    tbl[5] = '{len: 257, gap_max: 1, exp_err: 1'b1};
    tbl[6] = '{len: 9,   gap_max: 2, exp_err: 1'b0};
    tbl[7] = '{len: 4096,gap_max: 0, exp_err: 1'b1};

    Reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset values
    chk("rst_rx_ready",   32'(rx_ready),     32'd1);
    chk("rst_we",         32'(imem_we),      32'd0);
    chk("rst_addr",       32'(imem_addr),    32'd0);
    chk("rst_wdata",      imem_wdata,        32'd0);
    chk("rst_core_reset", 32'(core_reset),   32'd1);
    chk("rst_boot_done",  32'(boot_done),    32'd0);
    chk("rst_err",        32'(err_overflow), 32'd0);

    // reload outside DONE is ignored
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_ign_rx_ready", 32'(rx_ready), 32'd1);

    // Two-word image, back-to-back bytes
    clear_log();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h00500013, 0);
    chk("t1_we0",   32'(imem_we),   32'd1);
    chk("t1_addr0", 32'(imem_addr), 32'd0);
    chk("t1_data0", imem_wdata,     32'h00500013);
    send_word(32'h00A00093, 0);
    chk("t1_we1",   32'(imem_we),   32'd1);
    chk("t1_addr1", 32'(imem_addr), 32'd1);
    chk("t1_data1", imem_wdata,     32'h00A00093);
    chk("t1_core_reset_during_write", 32'(core_reset), 32'd1);
    tick();
    chk("t1_done",       32'(boot_done),  32'd1);
    chk("t1_core_reset", 32'(core_reset), 32'd0);
    chk("t1_rx_ready",   32'(rx_ready),   32'd0);
    chk("t1_we_off",     32'(imem_we),    32'd0);
    chk("t1_nwrites",    32'(got_addr.size()), 32'd2);

    // Zero-length image goes straight to DONE
    do_reset();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t2_done",       32'(boot_done),  32'd1);
    chk("t2_core_reset", 32'(core_reset), 32'd0);
    repeat (3) tick();
    chk("t2_nwrites",    32'(got_addr.size()), 32'd0);

    // Oversized image: sticky error, bytes and reload ignored
    do_reset();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("t3_err",        32'(err_overflow), 32'd1);
    chk("t3_rx_ready",   32'(rx_ready),     32'd0);
    chk("t3_core_reset", 32'(core_reset),   32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) tick();
    reload = 1'b1;
    tick();
    reload   = 1'b0;
    rx_valid = 1'b0;
    tick();
    chk("t3_err_sticky",  32'(err_overflow), 32'd1);
    chk("t3_done_low",    32'(boot_done),    32'd0);
    chk("t3_nwrites",     32'(got_addr.size()), 32'd0);
    do_reset();
    chk("t3_rst_err",      32'(err_overflow), 32'd0);
    chk("t3_rst_rx_ready", 32'(rx_ready),     32'd1);

    // One word with 3-cycle gaps; WE exactly one cycle after the 4th transfer
    clear_log();
    send_byte(8'h01, 3);
    send_byte(8'h00, 3);
    send_byte(8'h78, 3);
    send_byte(8'h56, 3);
    send_byte(8'h34, 3);
    chk("t4_no_early_we", 32'(imem_we), 32'd0);
    send_byte(8'h12, 3);
    chk("t4_we",   32'(imem_we),   32'd1);
    chk("t4_addr", 32'(imem_addr), 32'd0);
    chk("t4_data", imem_wdata,     32'h12345678);
    tick();
    chk("t4_done",     32'(boot_done),        32'd1);
    chk("t4_nwrites",  32'(got_addr.size()),  32'd1);

    // Reset in the middle of a two-word load
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h11, 0);
    Reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    tick();
    Reset    = 1'b0;
    rx_valid = 1'b0;
    clear_log();
    chk("t5_rx_ready",   32'(rx_ready),   32'd1);
    chk("t5_core_reset", 32'(core_reset), 32'd1);
    chk("t5_addr",       32'(imem_addr),  32'd0);
    chk("t5_wdata",      imem_wdata,      32'd0);
    repeat (5) tick();
    chk("t5_no_we",      32'(got_addr.size()), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h0badc0de, 1);
    chk("t5_we",    32'(imem_we),   32'd1);
    chk("t5_addr2", 32'(imem_addr), 32'd0);
    chk("t5_data",  imem_wdata,     32'h0badc0de);
    tick();
    chk("t5_done",  32'(boot_done), 32'd1);

    // reload from DONE starts a new image at address 0
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("t6_core_reset", 32'(core_reset), 32'd1);
    chk("t6_done_low",   32'(boot_done),  32'd0);
    chk("t6_rx_ready",   32'(rx_ready),   32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    chk("t6_we",   32'(imem_we),   32'd1);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_data", imem_wdata,     32'hDEADBEEF);
    tick();
    chk("t6_done", 32'(boot_done), 32'd1);

    // Randomized image table; errors leave via Reset, completions via reload
    do_reset();
    for (int v = 0; v < 8; v++) begin
      run_load(tbl[v].len, tbl[v].gap_max, tbl[v].exp_err);
      if (tbl[v].exp_err) begin
        do_reset();
      end else begin
        reload = 1'b1;
        tick();
        reload = 1'b0;
      end
      chk($sformatf("tbl%0d_restart_ready", v), 32'(rx_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
